// File: rtl/reg_file4_if.sv
// Bus bundle for the four-entry register file: operation/select inputs,
// the two read ports and the per-entry wrap pulses.
interface reg_file4_if #(
    parameter int NBits = 8
);
    logic [NBits-1:0] i;
    logic [1:0]       funsel;
    logic [3:0]       regsel;
    logic [1:0]       osel_a;
    logic [1:0]       osel_b;
    logic [NBits-1:0] out_a;
    logic [NBits-1:0] out_b;
    logic [3:0]       wrap;

    modport master (
        output i, funsel, regsel, osel_a, osel_b,
        input  out_a, out_b, wrap
    );

    modport slave (
        input  i, funsel, regsel, osel_a, osel_b,
        output out_a, out_b, wrap
    );
endinterface

// File: rtl/reg_file4.sv
// Four-entry register file with a shared clear/load/decrement/increment port,
// two combinational read ports and per-entry wrap pulses.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle load/clear to the read ports.
module reg_file4 #(
    parameter int NBits = 8
) (
    input logic        clk,
    input logic        rst_n,
    reg_file4_if.slave bus
);
    typedef enum logic [1:0] {
        FN_CLEAR = 2'b00,
        FN_LOAD  = 2'b01,
        FN_DEC   = 2'b10,
        FN_INC   = 2'b11
    } fun_e;

    localparam logic [NBits-1:0] AllOnes = '1;

    fun_e             fun;
    logic [NBits-1:0] regs [4];
    logic [3:0]       wrap_q;
    logic [NBits-1:0] out_a;
    logic [NBits-1:0] out_b;

    assign fun = fun_e'(bus.funsel);

    // NOTE: sequential state uses non-blocking assignments so every entry sees
    // the pre-edge value of every other register; blocking here would order-couple them.
    // The four entries are flops, not a RAM macro, so resetting them all is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) regs[k] <= '0;
            wrap_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wrap_q[k] <= 1'b0;
                if (bus.regsel[k]) begin
                    unique case (fun)
                        FN_CLEAR: regs[k] <= '0;
                        FN_LOAD:  regs[k] <= bus.i;
                        FN_DEC: begin
                            regs[k]   <= regs[k] - 1'b1;
                            wrap_q[k] <= (regs[k] == '0);
                        end
                        FN_INC: begin
                            regs[k]   <= regs[k] + 1'b1;
                            wrap_q[k] <= (regs[k] == AllOnes);
                        end
                    endcase
                end
            end
        end
    end

    // NOTE: each output gets its registered value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        out_a = regs[bus.osel_a];
        out_b = regs[bus.osel_b];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && bus.regsel[bus.osel_a]) begin
            if (fun == FN_LOAD)       out_a = bus.i;
            else if (fun == FN_CLEAR) out_a = '0;
        end
        if (rst_n && bus.regsel[bus.osel_b]) begin
            if (fun == FN_LOAD)       out_b = bus.i;
            else if (fun == FN_CLEAR) out_b = '0;
        end
`else
        // Reads of an entry being written this cycle return the old contents.
`endif
    end

    assign bus.out_a = out_a;
    assign bus.out_b = out_b;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_reg_file4.sv
// Self-checking bench for reg_file4: directed scenarios followed by random
// operations, compared against an arithmetic model of the four entries.
module tb_reg_file4;
    localparam int NB  = 8;
    localparam int MOD = 1 << NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    reg_file4_if #(.NBits(NB)) bus ();

    reg_file4 #(.NBits(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned mdl [4];
    logic [3:0]  mwrap;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a read port should show right now: stored value, plus forwarding when built in.
    function automatic logic [NB-1:0] exp_read(input logic [1:0] sel);
        logic [NB-1:0] v;
        v = NB'(mdl[sel]);
`ifdef REGFILE_BYPASS_EN
        if (rst_n && bus.regsel[sel]) begin
            if (bus.funsel == 2'b01)      v = bus.i;
            else if (bus.funsel == 2'b00) v = '0;
        end
`endif
        return v;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                mdl[k]   = 0;
                mwrap[k] = 1'b0;
            end else if (!bus.regsel[k]) begin
                mwrap[k] = 1'b0;
            end else begin
                mwrap[k] = 1'b0;
                case (bus.funsel)
                    2'b00: mdl[k] = 0;
                    2'b01: mdl[k] = int'(bus.i);
                    2'b10: begin
                        mwrap[k] = (mdl[k] == 0);
                        mdl[k]   = (mdl[k] + MOD - 1) % MOD;
                    end
                    default: begin
                        mwrap[k] = (mdl[k] == MOD - 1);
                        mdl[k]   = (mdl[k] + 1) % MOD;
                    end
                endcase
            end
        end
    endtask

    // Drive one cycle: called just after a negedge, returns just after the next negedge.
    task automatic step(input logic r, input logic [NB-1:0] d, input logic [1:0] fs,
                        input logic [3:0] rs, input logic [1:0] oa, input logic [1:0] ob,
                        input bit pre_check);
        rst_n      = r;
        bus.i      = d;
        bus.funsel = fs;
        bus.regsel = rs;
        bus.osel_a = oa;
        bus.osel_b = ob;
        #1;
        if (pre_check) begin
            check("pre_out_a", 32'(bus.out_a), 32'(exp_read(oa)));
            check("pre_out_b", 32'(bus.out_b), 32'(exp_read(ob)));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out_a", 32'(bus.out_a), 32'(exp_read(oa)));
        check("out_b", 32'(bus.out_b), 32'(exp_read(ob)));
        check("wrap", 32'(bus.wrap), 32'(mwrap));
    endtask

    initial begin
        bus.i = '0; bus.funsel = 2'b00; bus.regsel = 4'b0000;
        bus.osel_a = 2'd0; bus.osel_b = 2'd0;
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        mwrap = '0;
        @(negedge clk);

        // Power-up reset; state before it is undefined, so no pre-edge read check.
        step(1'b0, 8'h00, 2'b00, 4'b0000, 2'd0, 2'd3, 1'b0);

        // Reset overrides a broadcast load.
        step(1'b1, 8'hA5, 2'b01, 4'b1111, 2'd0, 2'd3, 1'b1);
        step(1'b0, 8'hA5, 2'b01, 4'b1111, 2'd1, 2'd2, 1'b1);
        check("rst_out_a", 32'(bus.out_a), 32'h00);
        check("rst_out_b", 32'(bus.out_b), 32'h00);
        check("rst_wrap", 32'(bus.wrap), 32'h0);

        // Selective load, then dual reads.
        step(1'b1, 8'h3C, 2'b01, 4'b0101, 2'd0, 2'd2, 1'b1);
        step(1'b1, 8'h00, 2'b10, 4'b0000, 2'd0, 2'd2, 1'b1);
        check("sel_r0", 32'(bus.out_a), 32'h3C);
        check("sel_r2", 32'(bus.out_b), 32'h3C);
        step(1'b1, 8'h00, 2'b10, 4'b0000, 2'd1, 2'd1, 1'b1);
        check("sel_r1a", 32'(bus.out_a), 32'h00);
        check("sel_r1b", 32'(bus.out_b), 32'h00);

        // Increment wrap on R1: FF, 00 (wrap), 01.
        step(1'b1, 8'hFE, 2'b01, 4'b0010, 2'd1, 2'd3, 1'b1);
        step(1'b1, 8'h00, 2'b11, 4'b0010, 2'd1, 2'd3, 1'b1);
        check("inc_ff", 32'(bus.out_a), 32'hFF);
        check("inc_ff_wrap", 32'(bus.wrap), 32'h0);
        step(1'b1, 8'h00, 2'b11, 4'b0010, 2'd1, 2'd3, 1'b1);
        check("inc_00", 32'(bus.out_a), 32'h00);
        check("inc_00_wrap", 32'(bus.wrap), 32'h2);
        step(1'b1, 8'h00, 2'b11, 4'b0010, 2'd1, 2'd3, 1'b1);
        check("inc_01", 32'(bus.out_a), 32'h01);
        check("inc_01_wrap", 32'(bus.wrap), 32'h0);

        // Decrement with two entries selected; only R3 wraps.
        step(1'b1, 8'h01, 2'b01, 4'b0001, 2'd0, 2'd3, 1'b1);
        step(1'b1, 8'h00, 2'b01, 4'b1000, 2'd0, 2'd3, 1'b1);
        step(1'b1, 8'h00, 2'b10, 4'b1001, 2'd0, 2'd3, 1'b1);
        check("dec_r0", 32'(bus.out_a), 32'h00);
        check("dec_r3", 32'(bus.out_b), 32'hFF);
        check("dec_wrap", 32'(bus.wrap), 32'h8);

        // Same-cycle read of the entry being loaded.
        step(1'b1, 8'h77, 2'b01, 4'b0100, 2'd2, 2'd0, 1'b1);
        check("wr_next", 32'(bus.out_a), 32'h77);

        // A wrap pending in an inc sequence is discarded by reset.
        step(1'b1, 8'hFF, 2'b01, 4'b0001, 2'd0, 2'd1, 1'b1);
        step(1'b0, 8'h00, 2'b11, 4'b0001, 2'd0, 2'd1, 1'b1);
        check("rst_inc_wrap", 32'(bus.wrap), 32'h0);

        // Random traffic biased toward wrap boundaries.
        for (int n = 0; n < 400; n++) begin
            logic          r;
            logic [NB-1:0] d;
            logic [1:0]    fs;
            r  = ($urandom_range(0, 24) != 0);
            fs = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(0, 1))) : 2'(($urandom_range(2, 3)));
            case ($urandom_range(0, 3))
                0:       d = 8'hFF;
                1:       d = 8'h00;
                2:       d = NB'($urandom_range(0, 3));
                default: d = NB'($urandom);
            endcase
            step(r, d, fs, 4'($urandom), 2'($urandom), 2'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_file4.md
Name: reg_file4

Overview:
- Four-entry general-purpose register file, NBits wide, with one write/modify port and two independent read ports.
- Every selected entry applies the same micro-operation each cycle, using the team's standard function-select encoding (clear/load/decrement/increment).
- Sits downstream of the datapath input mux and upstream of the ALU. out_a and out_b feed the ALU A/B operands.
- Per-entry wrap flags go to the control unit for loop-count detection.

Parameters:
- NBits, 8, data width of each entry and of i/out_a/out_b (minimum 2).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous, active-low reset; sampled on posedge clk.
- i  input  NBits  load data, shared by all entries.
- funsel  input  2  operation: 00 clear, 01 load, 10 decrement, 11 increment.
- regsel  input  4  per-entry enable mask; bit k=1 applies funsel to entry Rk.
- osel_a  input  2  read-port A entry select.
- osel_b  input  2  read-port B entry select.
- out_a  output  NBits  contents of entry osel_a.
- out_b  output  NBits  contents of entry osel_b.
- wrap  output  4  registered one-cycle pulse per entry, set when that entry wrapped on the previous edge.

Behaviour:
- Interface (fixed): single clock clk; reset rst_n is synchronous and active-low.
- Reset:
  - At posedge clk with rst_n=0: R0..R3 <= 0 and wrap <= 4'b0000.
  - Reset overrides regsel/funsel.
  - Reset in the middle of an increment/decrement sequence discards that operation; no wrap pulse follows.
  - out_a and out_b read 0 from the cycle after the reset edge.
- Update, per entry k, at posedge clk with rst_n=1:
  - regsel[k]=0: Rk holds; wrap[k] <= 0.
  - funsel=00: Rk <= 0.
  - funsel=01: Rk <= i.
  - funsel=10: Rk <= Rk-1, modulo 2^NBits. 0 becomes all-ones, with wrap[k] <= 1.
  - funsel=11: Rk <= Rk+1, modulo 2^NBits. All-ones becomes 0, with wrap[k] <= 1.
  - Otherwise wrap[k] <= 0.
- Multiple regsel bits set: each selected entry performs the operation independently on its own value, in the same edge (e.g. load broadcasts i to all selected entries).
- regsel=0000: no state change; all wrap bits clear next edge.
- Reads:
  - out_a = R[osel_a] and out_b = R[osel_b], combinational from current state.
  - Zero-cycle latency from select change; one-cycle latency from a write to its visibility.
  - osel_a == osel_b is legal; both ports show the same value.
- Read of an entry being written in the same cycle returns the old value (no bypass, unless the optional feature is compiled in).
- wrap is purely registered, high for exactly one cycle per wrapping edge. Consecutive wrapping ops (e.g. NBits=2, continuous increment) pulse once every 2^NBits cycles.
- No X propagation: all state is defined after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding on both read ports. If rst_n=1, funsel=01, and regsel[osel_x]=1, then out_x = i combinationally in the same cycle.
  - If rst_n=1, funsel=00, and regsel[osel_x]=1, then out_x = 0.
  - Increment/decrement are not forwarded.
- Undefined: reads always return registered state (old value during the write cycle).
- State update and wrap behaviour are identical in both builds.

Test Plan:
1. Reset: load 8'hA5 into all entries, then drive rst_n=0 for one edge with funsel=01, regsel=1111 -> all entries read 8'h00 and wrap=0000 next cycle.
2. Selective load: i=8'h3C, funsel=01, regsel=0101 -> R0=R2=8'h3C, while R1/R3 stay at their prior 8'h00.
3. Dual read: osel_a=0, osel_b=2 -> both read 8'h3C; then osel_a=osel_b=1 -> both read 8'h00.
4. Increment wrap: load R1=8'hFE, then funsel=11 with regsel=0010 for 3 cycles -> R1 reads FF, 00, 01 on successive cycles, with wrap[1] high only in the cycle R1 reads 00.
5. Decrement wrap with multi-select: R0=8'h01, R3=8'h00, funsel=10, regsel=1001 for 1 cycle -> R0=8'h00 with wrap[0]=0; R3=8'hFF with wrap[3]=1.
6. Same-cycle read of written entry: osel_a=2, i=8'h77, funsel=01, regsel=0100 -> out_a shows the old value in that cycle (8'h77 if built with REGFILE_BYPASS_EN), and 8'h77 on the next cycle in both builds.
